// File: rtl/rl_pkg.sv
// Shared definitions for the RL action-selection datapath.
//   FIX_W / FRAC_W : Q8.8 fixed-point geometry used by rand/epsilon/Q-values
//   q_value_t      : signed Q8.8 Q-value
//   state_t        : epsilon-greedy selector FSM states
package rl_pkg;

  localparam int FIX_W  = 16;
  localparam int FRAC_W = 8;

  typedef logic signed [FIX_W-1:0] q_value_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECIDE = 3'd1,
    ST_SCAN   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/q_argmax.sv
// Running signed maximum with index tracker.
//   clk, rst      : clock, synchronous active-high reset
//   init          : this sample seeds the running best unconditionally
//   sample_valid  : sample/idx carry a Q-value this cycle
//   sample, idx   : Q-value and the action index it belongs to
//   best_idx      : argmax including the current sample (combinational
//                   view, so the caller can capture it on the same edge
//                   that the last sample arrives)
module q_argmax #(
  parameter int Q_W   = 16,
  parameter int ACT_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init,
  input  logic                    sample_valid,
  input  logic signed [Q_W-1:0]   sample,
  input  logic        [ACT_W-1:0] idx,
  output logic        [ACT_W-1:0] best_idx
);

  logic signed [Q_W-1:0]   r_best_val;
  logic        [ACT_W-1:0] r_best_idx;
  logic                    w_take;

  // Strictly greater replaces; equal keeps the earlier (lower) index.
  assign w_take   = sample_valid && (init || (sample > r_best_val));
  assign best_idx = w_take ? idx : r_best_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_best_val <= '0;
      r_best_idx <= '0;
    end else if (w_take) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples pre-edge values regardless of block ordering.
      r_best_val <= sample;
      r_best_idx <= idx;
    end
  end

endmodule

// File: rtl/epsilon_greedy_selector.sv
// Epsilon-greedy action selector.
//   clk, rst     : clock, synchronous active-high reset
//   start        : request pulse, accepted only in IDLE
//   rand_in      : Q8.8 random fraction from the Randomizer
//   epsilon      : Q8.8 explore threshold
//   q_rd_en      : Q-table read strobe
//   q_addr       : action index being read
//   q_data       : signed Q8.8 Q-value, valid the cycle after q_rd_en
//   action       : selected action, held until the next result
//   explored     : 1 when action came from the explore path
//   action_valid : one-cycle pulse in the DONE cycle
//   busy         : high in every state except IDLE
module epsilon_greedy_selector
  import rl_pkg::*;
#(
  parameter int N_ACTIONS = 4,
  parameter int ACT_W     = 2,
  parameter int Q_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic        [FIX_W-1:0] rand_in,
  input  logic        [FIX_W-1:0] epsilon,
  output logic                    q_rd_en,
  output logic        [ACT_W-1:0] q_addr,
  input  logic signed [Q_W-1:0]   q_data,
  output logic        [ACT_W-1:0] action,
  output logic                    explored,
  output logic                    action_valid,
  output logic                    busy
);

  state_t r_state;
  state_t w_state_nxt;

  logic [FRAC_W-1:0] r_rand_frac;
  logic [ACT_W-1:0]  r_rand_act;
  logic [FIX_W-1:0]  r_eps;

  logic              r_q_rd_en;
  logic [ACT_W-1:0]  r_q_addr;
  logic              r_rd_d;
  logic [ACT_W-1:0]  r_idx_d;
  logic [ACT_W-1:0]  r_action;
  logic              r_explored;
  logic              r_action_valid;
  logic              r_busy;

  logic              w_explore;
  logic              w_scan_last;
  logic              w_accept;
  logic [ACT_W-1:0]  w_best_idx;
  logic              w_unused_rand;

  // Only the fraction and the action field of the random word matter.
  assign w_unused_rand = ^rand_in[FIX_W-1:FRAC_W+ACT_W];

  assign w_accept    = (r_state == ST_IDLE) && start;
  // Any integer part in epsilon means >= 1.0: always explore.
  assign w_explore   = (r_eps[FIX_W-1:FRAC_W] != '0) ||
                       (r_rand_frac < r_eps[FRAC_W-1:0]);
  assign w_scan_last = (r_q_addr == ACT_W'(N_ACTIONS - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    // NOTE: the default assignment first guarantees every path drives
    // w_state_nxt, so no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_DECIDE;
      ST_DECIDE: w_state_nxt = w_explore ? ST_DONE : ST_SCAN;
      ST_SCAN:   if (w_scan_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Request latches: pure data qualified by w_accept.
  // NOTE: these carry no reset; they are always written before being used,
  // and leaving them out of reset keeps the reset net off plain data flops.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rand_frac <= rand_in[FRAC_W-1:0];
      r_rand_act  <= rand_in[FRAC_W +: ACT_W];
      r_eps       <= epsilon;
    end
  end

  // Registered outputs and read pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_rd_en      <= 1'b0;
      r_q_addr       <= '0;
      r_rd_d         <= 1'b0;
      r_idx_d        <= '0;
      r_action       <= '0;
      r_explored     <= 1'b0;
      r_action_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      // Delay the read strobe/index by one cycle to line up with q_data.
      r_rd_d         <= r_q_rd_en;
      r_idx_d        <= r_q_addr;
      r_busy         <= (w_state_nxt != ST_IDLE);
      r_action_valid <= (w_state_nxt == ST_DONE);
      unique case (r_state)
        ST_DECIDE: begin
          if (w_explore) begin
            r_action   <= r_rand_act;
            r_explored <= 1'b1;
          end else begin
            r_q_rd_en <= 1'b1;
            r_q_addr  <= '0;
          end
        end
        ST_SCAN: begin
          if (w_scan_last) begin
            r_q_rd_en <= 1'b0;
            r_q_addr  <= '0;
          end else begin
            r_q_addr  <= r_q_addr + ACT_W'(1);
          end
        end
        // The final sample lands in DRAIN; capture the merged argmax.
        ST_DRAIN: begin
          r_action   <= w_best_idx;
          r_explored <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  q_argmax #(
    .Q_W   (Q_W),
    .ACT_W (ACT_W)
  ) u_argmax (
    .clk          (clk),
    .rst          (rst),
    .init         (r_rd_d && (r_idx_d == '0)),
    .sample_valid (r_rd_d),
    .sample       (q_data),
    .idx          (r_idx_d),
    .best_idx     (w_best_idx)
  );

  assign q_rd_en      = r_q_rd_en;
  assign q_addr       = r_q_addr;
  assign action       = r_action;
  assign explored     = r_explored;
  assign action_valid = r_action_valid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_epsilon_greedy_selector.sv
module tb_epsilon_greedy_selector;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [15:0]        rand_in;
  logic [15:0]        epsilon;
  logic               q_rd_en;
  logic [1:0]         q_addr;
  logic signed [15:0] q_data = '0;
  logic [1:0]         action;
  logic               explored;
  logic               action_valid;
  logic               busy;

  logic signed [15:0] q_tab [4];
  int checks = 0;
  int errors = 0;
  int hold_act = 0;

  always #5 clk = ~clk;

  // Q-table memory: one cycle read latency.
  always @(posedge clk) if (q_rd_en) q_data <= q_tab[q_addr];

  epsilon_greedy_selector #(.N_ACTIONS(4), .ACT_W(2), .Q_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rand_in      (rand_in),
    .epsilon      (epsilon),
    .q_rd_en      (q_rd_en),
    .q_addr       (q_addr),
    .q_data       (q_data),
    .action       (action),
    .explored     (explored),
    .action_valid (action_valid),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_q(input int a, input int b, input int c, input int d);
    q_tab[0] = 16'(a); q_tab[1] = 16'(b); q_tab[2] = 16'(c); q_tab[3] = 16'(d);
  endtask

  // One request checked against the reference model. glitch=1 adds start
  // pulses during the scan and in the DONE cycle.
  task automatic run_op(input logic [15:0] r, input logic [15:0] e, input bit glitch);
    bit exp_explore;
    int exp_act, exp_lat, n, reads, best, extra;
    bit got;
    exp_explore = (e >= 16'h0100) || ((r % 256) < (e % 256));
    if (exp_explore) begin
      exp_act = (r >> 8) % 4;
      exp_lat = 2;
    end else begin
      best = 0;
      for (int i = 1; i < 4; i++) if (q_tab[i] > q_tab[best]) best = i;
      exp_act = best;
      exp_lat = 4 + 3;
    end
    @(negedge clk);
    rand_in = r; epsilon = e; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; rand_in = 16'($urandom); epsilon = 16'($urandom);
    n = 0; reads = 0; got = 0;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      if (glitch && n == 3) start = 1'b1;
      else if (glitch && n == 4) start = 1'b0;
      if (q_rd_en) begin
        check("q_addr_seq", q_addr, reads);
        reads++;
      end
      if (action_valid) got = 1;
    end
    check("valid_seen", got, 1);
    check("latency", n, exp_lat);
    check("read_count", reads, exp_explore ? 0 : 4);
    check("action", action, exp_act);
    check("explored", explored, exp_explore);
    check("busy_in_done", busy, 1);
    if (glitch) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("valid_pulse_end", action_valid, 0);
    check("idle_busy", busy, 0);
    check("action_hold", action, exp_act);
    hold_act = exp_act;
    if (glitch) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (action_valid || busy) extra++;
      end
      check("no_extra_op", extra, 0);
    end
  endtask

  initial begin
    int vcount;
    rst = 1'b1; start = 1'b0; rand_in = '0; epsilon = '0;
    set_q(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_action", action, 0);
    check("rst_explored", explored, 0);
    check("rst_valid", action_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", q_rd_en, 0);
    check("rst_addr", q_addr, 0);
    @(negedge clk) rst = 1'b0;

    // Exploit with epsilon = 0
    set_q(16'h0500, -16'sh0300, 16'h0900, 16'h0200);
    run_op(16'h4242, 16'h0000, 0);
    // epsilon = 1.0 always explores
    run_op(16'h4242, 16'h0100, 0);
    // Fractional threshold: below explores, above exploits
    run_op(16'h0342, 16'h0050, 0);
    run_op(16'h0360, 16'h0050, 0);
    // Ties among negatives keep lowest index
    set_q(-16'sh0100, -16'sh0080, -16'sh0080, -16'sh0200);
    run_op(16'h0000, 16'h0000, 0);
    // start during SCAN and DONE ignored
    set_q(16'h0010, 16'h0020, 16'h0030, 16'h0300);
    run_op(16'h1280, 16'h0010, 1);
    run_op(16'h0000, 16'h0000, 0);

    // Reset during the second SCAN cycle
    set_q(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    @(negedge clk);
    rand_in = 16'h0000; epsilon = 16'h0000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("midscan_rd_en", q_rd_en, 1);
    check("midscan_addr", q_addr, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_action", action, 0);
    check("mrst_explored", explored, 0);
    check("mrst_valid", action_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_rd_en", q_rd_en, 0);
    check("mrst_addr", q_addr, 0);
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (action_valid) vcount++;
    end
    check("abandoned_no_valid", vcount, 0);
    run_op(16'h0000, 16'h0000, 0);

    // Randomized requests against the model
    for (int t = 0; t < 24; t++) begin
      logic [15:0] r, e;
      int sel;
      for (int i = 0; i < 4; i++) q_tab[i] = 16'(($urandom_range(0, 15) - 8) * 64);
      r = 16'($urandom);
      sel = $urandom_range(0, 3);
      if (sel == 0)      e = 16'h0000;
      else if (sel == 1) e = 16'(16'h0100 + $urandom_range(0, 16'h0eff));
      else               e = 16'($urandom_range(0, 255));
      run_op(r, e, (t % 8) == 7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
